// File: rtl/flit_link_tx.sv
// Reader side of a router input FIFO: pops flits, locks the output port for a
// whole packet via req/grant, and drives a registered valid/ready link.
//
// state | meaning
// IDLE  | waiting for a head flit at the FIFO head; orphan flits are dropped
// REQ   | head seen, requesting the output port from the allocator
// SEND  | port locked, streaming flits until the tail is popped
module flit_link_tx #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  req,
  input  logic                  grant,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic                  pkt_active,
  output logic [CNT_WIDTH-1:0]  flit_cnt,
  output logic [CNT_WIDTH-1:0]  pkt_cnt,
  output logic                  proto_err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;

  logic [1:0]            state_q, state_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [CNT_WIDTH-1:0]  flit_cnt_q, flit_cnt_d;
  logic [CNT_WIDTH-1:0]  pkt_cnt_q, pkt_cnt_d;
  logic                  proto_err_q, proto_err_d;

  logic [1:0] flit_type;
  logic       is_head, is_tail, slot_free, xfer;
  logic       pop_send, pop_drop;

  assign flit_type = fifo_dout[DATA_WIDTH-1 -: 2];
  assign is_head   = (flit_type == 2'b01) || (flit_type == 2'b11);
  assign is_tail   = (flit_type == 2'b10) || (flit_type == 2'b11);
  assign slot_free = ~out_valid_q | out_ready;
  assign xfer      = out_valid_q & out_ready;

  assign pop_send = (state_q == ST_SEND) & ~fifo_empty & slot_free;
  assign pop_drop = (state_q == ST_IDLE) & ~fifo_empty & ~is_head;

  // Gated by rst_n so an orphan flit at the FIFO head is not popped during reset.
  assign fifo_rd_en = rst_n & (pop_send | pop_drop);
  assign req        = rst_n & ((state_q == ST_REQ) | (state_q == ST_SEND));
  assign pkt_active = rst_n & (state_q == ST_SEND);

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    flit_cnt_d  = flit_cnt_q;
    pkt_cnt_d   = pkt_cnt_q;
    proto_err_d = proto_err_q;

    if (xfer) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          if (is_head) begin
            state_d    = ST_REQ;
            flit_cnt_d = '0;
          end else begin
            proto_err_d = 1'b1;
          end
        end
      end
      ST_REQ: begin
        if (grant) begin
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (pop_send) begin
          out_valid_d = 1'b1;
          out_data_d  = fifo_dout;
          if (flit_cnt_q != '1) begin
            flit_cnt_d = flit_cnt_q + 1'b1;
          end
          if (is_head && (flit_cnt_q != '0)) begin
            proto_err_d = 1'b1;
          end
          if (is_tail) begin
            state_d   = ST_IDLE;
            pkt_cnt_d = pkt_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      flit_cnt_q  <= '0;
      pkt_cnt_q   <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      flit_cnt_q  <= flit_cnt_d;
      pkt_cnt_q   <= pkt_cnt_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign flit_cnt  = flit_cnt_q;
  assign pkt_cnt   = pkt_cnt_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_flit_link_tx.sv
// Directed bench for flit_link_tx: behavioural FIFO, link monitor, a per-cycle
// vector table for the single-flit packet and hand sequences for the rest.
module tb_flit_link_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [31:0] fifo_dout;
  logic        req;
  logic        grant;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic        pkt_active;
  logic [7:0]  flit_cnt;
  logic [7:0]  pkt_cnt;
  logic        proto_err;

  always #5 clk = ~clk;

  flit_link_tx #(.DATA_WIDTH(32), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout),
    .req(req), .grant(grant),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .pkt_active(pkt_active), .flit_cnt(flit_cnt), .pkt_cnt(pkt_cnt),
    .proto_err(proto_err)
  );

  // FIFO model: asynchronous read of the head, pop on the rising edge.
  logic [31:0] mem [0:127];
  logic [6:0]  wp = 7'd0;
  logic [6:0]  rp = 7'd0;
  assign fifo_empty = (wp == rp);
  assign fifo_dout  = mem[rp];
  always @(posedge clk) if (fifo_rd_en && (wp != rp)) rp <= rp + 7'd1;

  task automatic push(input logic [31:0] f);
    mem[wp] = f;
    wp = wp + 7'd1;
  endtask

  // Link monitor: records every transfer with the cycle it happened in.
  int          cyc = 0;
  int          ncap = 0;
  logic [31:0] cap_d [0:63];
  int          cap_c [0:63];
  always @(negedge clk) begin
    cyc = cyc + 1;
    #2;
    if (rst_n && out_valid && out_ready && ncap < 64) begin
      cap_d[ncap] = out_data;
      cap_c[ncap] = cyc;
      ncap = ncap + 1;
    end
  end

  int nchk = 0;
  int nerr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_caps(input int target, input string name);
    int k;
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      #3;
      if (ncap >= target) break;
    end
    if (ncap < target) begin
      nchk++;
      nerr++;
      $display("FAIL %s timeout: got %0d transfers, expected %0d", name, ncap, target);
    end
  endtask

  task automatic check_caps(input int base, input logic [31:0] exp [0:4], input int n,
                            input string name);
    for (int i = 0; i < n; i++) check($sformatf("%s_flit%0d", name, i), cap_d[base+i], exp[i]);
  endtask

  typedef struct packed {
    logic        grant;
    logic        ready;
    logic        req;
    logic        rd_en;
    logic        valid;
    logic [31:0] data;
    logic        act;
    logic [7:0]  pk;
  } vec_t;

  vec_t        tbl [0:5];
  logic [31:0] exp_f [0:4];
  int          base;
  logic        ok;

  initial begin
    // Single HEADTAIL packet, cycle 0 = first cycle out of reset, grant in cycle 2.
    tbl[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 8'd0};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 8'd0};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 8'd0};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 8'd0};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hC000_00AA, 1'b0, 8'd1};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hC000_00AA, 1'b0, 8'd1};

    rst_n = 1'b0;
    grant = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    push(32'hC000_00AA);
    #1;
    check("rst_req", {31'd0, req}, 32'd0);
    check("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_cnts", {16'd0, flit_cnt, pkt_cnt}, 32'd0);
    check("rst_err", {31'd0, proto_err}, 32'd0);

    // T2: vector table
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      grant = tbl[i].grant;
      out_ready = tbl[i].ready;
      #1;
      check($sformatf("t2_c%0d_req", i), {31'd0, req}, {31'd0, tbl[i].req});
      check($sformatf("t2_c%0d_rd_en", i), {31'd0, fifo_rd_en}, {31'd0, tbl[i].rd_en});
      check($sformatf("t2_c%0d_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].valid});
      check($sformatf("t2_c%0d_data", i), out_data, tbl[i].data);
      check($sformatf("t2_c%0d_active", i), {31'd0, pkt_active}, {31'd0, tbl[i].act});
      check($sformatf("t2_c%0d_pkt_cnt", i), {24'd0, pkt_cnt}, {24'd0, tbl[i].pk});
    end

    // T3: streaming HEAD, 3xBODY, TAIL
    @(negedge clk);
    exp_f = '{32'h4000_0001, 32'h0000_0002, 32'h0000_0003, 32'h0000_0004, 32'h8000_0005};
    base = ncap;
    for (int i = 0; i < 5; i++) push(exp_f[i]);
    grant = 1'b1;
    out_ready = 1'b1;
    wait_caps(base + 5, "t3");
    check_caps(base, exp_f, 5, "t3");
    ok = 1'b1;
    for (int i = 1; i < 5; i++) if (cap_c[base+i] != cap_c[base+i-1] + 1) ok = 1'b0;
    check("t3_consecutive", {31'd0, ok}, 32'd1);
    check("t3_flit_cnt", {24'd0, flit_cnt}, 32'd5);
    check("t3_pkt_cnt", {24'd0, pkt_cnt}, 32'd2);
    check("t3_err", {31'd0, proto_err}, 32'd0);

    // T4: backpressure for 3 cycles after two flits have crossed
    @(negedge clk);
    exp_f = '{32'h4000_0010, 32'h0000_0011, 32'h0000_0012, 32'h0000_0013, 32'h8000_0014};
    base = ncap;
    for (int i = 0; i < 5; i++) push(exp_f[i]);
    wait_caps(base + 2, "t4_pre");
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      check($sformatf("t4_hold%0d_data", i), out_data, 32'h0000_0012);
      check($sformatf("t4_hold%0d_valid", i), {31'd0, out_valid}, 32'd1);
      check($sformatf("t4_hold%0d_rd_en", i), {31'd0, fifo_rd_en}, 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    wait_caps(base + 5, "t4");
    check_caps(base, exp_f, 5, "t4");
    check("t4_ncap", ncap, base + 5);
    check("t4_pkt_cnt", {24'd0, pkt_cnt}, 32'd3);
    check("t4_flit_cnt", {24'd0, flit_cnt}, 32'd5);

    // T5: orphan BODY at the FIFO head while idle
    repeat (2) @(negedge clk);
    base = ncap;
    push(32'h0000_0055);
    #1;
    check("t5_rd_en", {31'd0, fifo_rd_en}, 32'd1);
    check("t5_req0", {31'd0, req}, 32'd0);
    @(negedge clk);
    #1;
    check("t5_err", {31'd0, proto_err}, 32'd1);
    check("t5_req1", {31'd0, req}, 32'd0);
    check("t5_dropped", {31'd0, fifo_empty}, 32'd1);
    check("t5_valid", {31'd0, out_valid}, 32'd0);
    check("t5_pkt_cnt", {24'd0, pkt_cnt}, 32'd3);

    // T6: lock held with grant gone and the FIFO empty mid-packet
    exp_f = '{32'h4000_0020, 32'h0000_0021, 32'h8000_0022, 32'h0, 32'h0};
    base = ncap;
    push(exp_f[0]);
    push(exp_f[1]);
    grant = 1'b1;
    wait_caps(base + 1, "t6_head");
    grant = 1'b0;
    wait_caps(base + 2, "t6_body");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      check($sformatf("t6_gap%0d_req", i), {31'd0, req}, 32'd1);
      check($sformatf("t6_gap%0d_active", i), {31'd0, pkt_active}, 32'd1);
      check($sformatf("t6_gap%0d_rd_en", i), {31'd0, fifo_rd_en}, 32'd0);
    end
    push(exp_f[2]);
    wait_caps(base + 3, "t6_tail");
    check_caps(base, exp_f, 3, "t6");
    check("t6_pkt_cnt", {24'd0, pkt_cnt}, 32'd4);
    check("t6_req_drop", {31'd0, req}, 32'd0);

    // T1: asynchronous reset mid-SEND with a flit stuck in the output register
    @(negedge clk);
    push(32'h4000_0030);
    grant = 1'b1;
    out_ready = 1'b0;
    for (int k = 0; k < 20 && !out_valid; k++) begin
      @(negedge clk);
      #1;
    end
    check("t1_pre_valid", {31'd0, out_valid}, 32'd1);
    check("t1_pre_active", {31'd0, pkt_active}, 32'd1);
    push(32'h0000_0031);
    #1;
    rst_n = 1'b0;
    #1;
    check("t1_req", {31'd0, req}, 32'd0);
    check("t1_valid", {31'd0, out_valid}, 32'd0);
    check("t1_data", out_data, 32'd0);
    check("t1_flit_cnt", {24'd0, flit_cnt}, 32'd0);
    check("t1_pkt_cnt", {24'd0, pkt_cnt}, 32'd0);
    check("t1_err", {31'd0, proto_err}, 32'd0);
    check("t1_active", {31'd0, pkt_active}, 32'd0);
    check("t1_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    repeat (2) @(negedge clk);
    #1;
    check("t1_fifo_kept", {31'd0, fifo_empty}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
